// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: pipeline hazard/flush controller; PIPE_CTRL_PERF_EN adds HOLD/flush perf counters.
// Latency: stall/flush are combinational from inputs; stage_valid, ctrl_state and flags update one edge later.
// Backpressure: the highest unflushed stallreq holds PC and stages 0..k, and stage k+1 takes a bubble.
module pipe_ctrl_n #(
  parameter int STAGES    = 5,
  parameter int STALL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic [2:0]        flush_upto,
  input  logic              in_valid,
  output logic [STAGES:0]   stall,
  output logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] stage_valid,
  output logic [1:0]        ctrl_state,
  output logic              stall_timeout,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0]  LAST_IDX  = 3'(STAGES - 1);
  localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);

  logic [2:0]        flush_lim;
  logic [STAGES-1:0] live_req;
  logic [STAGES-1:0] prev_valid;
  logic [3:0]        top_idx;
  logic              req_any;
  logic              hold_cyc;

  state_t            state_q, state_d;
  logic [STAGES-1:0] stage_valid_q, stage_valid_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic              stall_timeout_q, stall_timeout_d;

  // Flushed stages are dead this cycle, so their hold requests are masked out.
  always_comb begin
    flush_lim = (flush_upto > LAST_IDX) ? LAST_IDX : flush_upto;
    flush     = '0;
    for (int j = 0; j < STAGES; j++) begin
      flush[j] = flush_req && (3'(j) <= flush_lim);
    end
    live_req = stallreq & ~flush;
    req_any  = 1'b0;
    top_idx  = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (live_req[i]) begin
        req_any = 1'b1;
        top_idx = 4'(i);
      end
    end
    // top_idx is 4 bits wide so top_idx+1 cannot wrap for STAGES=8.
    stall = '0;
    for (int i = 0; i <= STAGES; i++) begin
      stall[i] = req_any && (4'(i) <= (top_idx + 4'd1));
    end
  end

  // stall[0] implies stall[1], so stage 0 never reaches the bubble branch.
  always_comb begin
    prev_valid    = {stage_valid_q[STAGES-2:0], in_valid};
    stage_valid_d = '0;
    for (int j = 0; j < STAGES; j++) begin
      if (flush[j])          stage_valid_d[j] = 1'b0;
      else if (stall[j+1])   stage_valid_d[j] = stage_valid_q[j];
      else if (stall[j])     stage_valid_d[j] = 1'b0;
      else                   stage_valid_d[j] = prev_valid[j];
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (flush_req)   state_d = ST_FLUSH;
    else if (|stall) state_d = ST_HOLD;
    hold_cyc   = (state_d == ST_HOLD);
    hold_cnt_d = '0;
    if (hold_cyc) begin
      hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
    end
    stall_timeout_d = stall_timeout_q || (hold_cnt_d >= STALL_LIM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_RUN;
      stage_valid_q   <= '0;
      hold_cnt_q      <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stage_valid_q   <= stage_valid_d;
      hold_cnt_q      <= hold_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stage_valid   = stage_valid_q;
  assign ctrl_state    = state_q;
  assign stall_timeout = stall_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (hold_cyc && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_req && (flush_count_q != 16'hFFFF))      flush_count_d  = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
